// File: rtl/pe_connect_array_pkg.sv
// Shared constants and the 3-tap dot-product helper for the row-stationary conv array.
package pe_connect_array_pkg;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned PROD_W = 16;
  localparam int unsigned OUT_W  = 16;
  localparam int unsigned KERNEL = 3;
  localparam int unsigned SUM_W  = PROD_W + 2;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned ROW_W  = KERNEL * PIX_W;

  // Tap j of the window multiplies tap j of the weight row.
  function automatic logic [SUM_W-1:0] dot3(input logic [ROW_W-1:0] win,
                                            input logic [ROW_W-1:0] wt);
    logic [SUM_W-1:0] s;
    logic [PROD_W-1:0] p;
    s = '0;
    for (int unsigned j = 0; j < KERNEL; j++) begin
      p = PROD_W'(win[j*PIX_W +: PIX_W]) * PROD_W'(wt[j*PIX_W +: PIX_W]);
      s = s + SUM_W'(p);
    end
    return s;
  endfunction

endpackage

// File: rtl/pe_connect_array_if.sv
// Pixel/weight/start bundle in from the line-buffer feeder, result out to pooling.
interface pe_connect_array_if #(
  parameter int unsigned IMG_ROW = 13
);
  import pe_connect_array_pkg::*;

  logic [IMG_ROW-1:0]       start;
  logic [CNT_W-1:0]         channel_packed;
  logic [IMG_ROW*PIX_W-1:0] img;
  logic [ROW_W-1:0]         weight_top;
  logic [ROW_W-1:0]         weight_mid;
  logic [ROW_W-1:0]         weight_bottom;
  logic [OUT_W-1:0]         out_value;

  modport master (
    output start, channel_packed, img, weight_top, weight_mid, weight_bottom,
    input  out_value
  );

  modport slave (
    input  start, channel_packed, img, weight_top, weight_mid, weight_bottom,
    output out_value
  );

endinterface

// File: rtl/pe_connect_array_pe_row.sv
// One PE: 3-pixel sliding window on an image row and its dot products with the kernel rows.
module pe_row
  import pe_connect_array_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [PIX_W-1:0] pix_i,
  input  logic [ROW_W-1:0] w_top_i,
  input  logic [ROW_W-1:0] w_mid_i,
  input  logic [ROW_W-1:0] w_bot_i,
  output logic [SUM_W-1:0] p_top_c_o,
  output logic [SUM_W-1:0] p_mid_c_o,
  output logic [SUM_W-1:0] p_bot_c_o
);

  // Packed as {w2, w1, w0}; a shift moves w1->w2, w0->w1 and loads the new pixel into w0.
  logic [ROW_W-1:0] win_q, win_d;

  always_comb begin
    win_d = win_q;
    if (en_i) begin
      win_d = {win_q[ROW_W-PIX_W-1:0], pix_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
    end else begin
      win_q <= win_d;
    end
  end

  assign p_top_c_o = dot3(win_q, w_top_i);
  assign p_mid_c_o = dot3(win_q, w_mid_i);
  assign p_bot_c_o = dot3(win_q, w_bot_i);

endmodule

// File: rtl/pe_connect_array.sv
// Row-stationary 3x3 convolution array: IMG_ROW PEs, vertical row-sum adder and
// per-output channel accumulator with a registered 16-bit result.
module pe_connect_array
  import pe_connect_array_pkg::*;
#(
  parameter int unsigned IMG_ROW    = 13,
  parameter int unsigned WEIGHT_ROW = 3
)(
  input  logic                clk,
  input  logic                reset,
  pe_connect_array_if.slave   bus
);

  localparam int unsigned W_BITS = WEIGHT_ROW * PIX_W;
  localparam int unsigned CMP_W  = CNT_W + 1;

  logic [W_BITS-1:0] w_top, w_mid, w_bot;
  logic [SUM_W-1:0]  p_top [IMG_ROW];
  logic [SUM_W-1:0]  p_mid [IMG_ROW];
  logic [SUM_W-1:0]  p_bot [IMG_ROW];
  logic [OUT_W-1:0]  cur_c;
  logic              en_c;
  logic [CMP_W-1:0]  c_eff_c;

  logic [OUT_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]  out_q, out_d;

  assign w_top = bus.weight_top;
  assign w_mid = bus.weight_mid;
  assign w_bot = bus.weight_bottom;

  for (genvar i = 0; i < IMG_ROW; i++) begin : g_pe
    pe_row u_pe (
      .clk       (clk),
      .rst_n     (reset),
      .en_i      (bus.start[i]),
      .pix_i     (bus.img[i*PIX_W +: PIX_W]),
      .w_top_i   (w_top),
      .w_mid_i   (w_mid),
      .w_bot_i   (w_bot),
      .p_top_c_o (p_top[i]),
      .p_mid_c_o (p_mid[i]),
      .p_bot_c_o (p_bot[i])
    );
  end

  // Window r spans PE rows r..r+2; the 16-bit sum wraps by design.
  always_comb begin
    cur_c = '0;
    for (int unsigned r = 0; r + 2 < IMG_ROW; r++) begin
      cur_c = cur_c + OUT_W'(p_top[r]) + OUT_W'(p_mid[r+1]) + OUT_W'(p_bot[r+2]);
    end
  end

  assign en_c    = |bus.start;
  assign c_eff_c = (bus.channel_packed == '0) ? CMP_W'(1) : CMP_W'(bus.channel_packed);

  // Closing on >= lets a shrunken channel count end an already-longer group at once.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    out_d = out_q;
    if (en_c) begin
      if ((CMP_W'(cnt_q) + CMP_W'(1)) >= c_eff_c) begin
        out_d = acc_q + cur_c;
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = acc_q + cur_c;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign bus.out_value = out_q;

endmodule

// File: tb/tb_pe_connect_array.sv
// Directed bench for pe_connect_array: hand-computed sums plus a small behavioural model.
module tb_pe_connect_array;

  localparam int unsigned IMG_ROW = 13;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  pe_connect_array_if #(.IMG_ROW(IMG_ROW)) bus ();

  pe_connect_array #(.IMG_ROW(IMG_ROW), .WEIGHT_ROW(3)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: windows, accumulator, counter, output.
  int unsigned mw [IMG_ROW][3];
  int unsigned macc, mcnt, mout;

  task automatic model_reset();
    for (int i = 0; i < IMG_ROW; i++)
      for (int j = 0; j < 3; j++) mw[i][j] = 0;
    macc = 0; mcnt = 0; mout = 0;
  endtask

  task automatic model_edge();
    int unsigned cur, ceff;
    logic [23:0] wt, wm, wb;
    logic [IMG_ROW*8-1:0] im;
    wt = bus.weight_top; wm = bus.weight_mid; wb = bus.weight_bottom; im = bus.img;
    if (bus.start == '0) return;
    cur = 0;
    for (int r = 0; r < IMG_ROW - 2; r++)
      for (int j = 0; j < 3; j++)
        cur += mw[r][j] * wt[8*j +: 8] + mw[r+1][j] * wm[8*j +: 8] + mw[r+2][j] * wb[8*j +: 8];
    cur = cur % 65536;
    ceff = (bus.channel_packed == 3'd0) ? 1 : int'(bus.channel_packed);
    if (mcnt + 1 >= ceff) begin
      mout = (macc + cur) % 65536; macc = 0; mcnt = 0;
    end else begin
      macc = (macc + cur) % 65536; mcnt = mcnt + 1;
    end
    for (int i = 0; i < IMG_ROW; i++) begin
      if (bus.start[i]) begin
        mw[i][2] = mw[i][1]; mw[i][1] = mw[i][0]; mw[i][0] = im[8*i +: 8];
      end
    end
  endtask

  task automatic tick();
    if (rst_n) model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] exp);
    n_cmp++;
    assert (bus.out_value === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, bus.out_value, exp);
    end
  endtask

  task automatic drive(input logic [7:0] pix, input logic [7:0] w,
                       input logic [IMG_ROW-1:0] st, input logic [2:0] c);
    bus.img            = {IMG_ROW{pix}};
    bus.weight_top     = {3{w}};
    bus.weight_mid     = {3{w}};
    bus.weight_bottom  = {3{w}};
    bus.start          = st;
    bus.channel_packed = c;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  logic [IMG_ROW-1:0] ones;
  logic [15:0] exp_t3 [8];

  initial begin
    n_cmp = 0; n_err = 0;
    ones = '1;
    rst_n = 1'b0;
    model_reset();
    drive(8'h00, 8'h00, '0, 3'd1);
    #12;
    check("reset_value", 16'd0);
    rst_n = 1'b1;

    // All ones, C=1: cur ramps 0,33,66 then settles at 99.
    drive(8'h01, 8'h01, ones, 3'd1);
    tick(); check("c1_e1", 16'd0);
    tick(); check("c1_e2", 16'd33);
    tick(); check("c1_e3", 16'd66);
    for (int k = 4; k <= 6; k++) begin
      tick(); check($sformatf("c1_e%0d", k), 16'd99);
    end

    // Same stimulus, C=2: pairs of row sums.
    do_reset();
    drive(8'h01, 8'h01, ones, 3'd2);
    exp_t3 = '{16'd0, 16'd33, 16'd33, 16'd165, 16'd165, 16'd198, 16'd198, 16'd198};
    for (int k = 0; k < 8; k++) begin
      tick(); check($sformatf("c2_e%0d", k + 1), exp_t3[k]);
    end

    // Async reset mid-run with out_value=198.
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset_now", 16'd0);
    tick(); check("reset_held_1", 16'd0);
    tick(); check("reset_held_2", 16'd0);
    rst_n = 1'b1;

    // One-hot walking start, only pixel row 0 nonzero.
    drive(8'h00, 8'h01, '0, 3'd2);
    bus.img[7:0] = 8'h01;
    for (int k = 0; k < 26; k++) begin
      bus.start = IMG_ROW'(1) << (k % IMG_ROW);
      tick();
      check($sformatf("walk_e%0d", k + 1), 16'(mout));
    end
    check("walk_final", 16'd4);

    // Saturated pixels/weights, C=7: sums wrap mod 2^16.
    do_reset();
    drive(8'hFF, 8'hFF, ones, 3'd7);
    for (int k = 1; k <= 6; k++) begin
      tick(); check($sformatf("ff_e%0d", k), 16'd0);
    end
    tick(); check("ff_e7", 16'd9199);
    for (int k = 8; k <= 10; k++) begin
      tick(); check($sformatf("ff_e%0d", k), 16'd9199);
    end

    // Idle mid-group: everything holds, then the group resumes where it left off.
    bus.start = '0;
    for (int k = 0; k < 5; k++) begin
      tick(); check($sformatf("idle_%0d", k), 16'd9199);
    end
    bus.start = ones;
    for (int k = 11; k <= 13; k++) begin
      tick(); check($sformatf("ff_e%0d", k), 16'd9199);
    end
    tick(); check("ff_e14", 16'd39093);
    check("ff_model", 16'(mout));

    // Channel count shrinks mid-group (3 -> 2 after two edges) closes at once; C=0 acts as 1.
    bus.channel_packed = 3'd3;
    tick(); check("shrink_e1", 16'd39093);
    tick(); check("shrink_e2", 16'd39093);
    bus.channel_packed = 3'd2;
    tick(); check("shrink_close", 16'd44841);
    bus.channel_packed = 3'd0;
    tick(); check("c0_as_1", 16'd14947);
    check("c0_model", 16'(mout));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
